// File: rtl/memory_responder.sv
// rtl/memory_responder.sv - dual-port word memory with fixed-latency read/write responses
module memory_responder #(
    parameter int MEM_DEPTH = 256,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        read_m1,
    input  logic [15:0] address1,
    output logic [15:0] data1,
    output logic        ready1,
    input  logic        read_m2,
    input  logic        write_m2,
    input  logic [15:0] address2,
    inout  wire  [15:0] data2,
    output logic        ready2
);
    localparam int         AW          = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [3:0] CNT_LOAD    = 4'(LATENCY - 1);
    localparam bit         DIRECT_DONE = (LATENCY == 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    logic [15:0] mem_q [MEM_DEPTH];

    state_e        p1_state_q, p1_state_d;
    logic [3:0]    p1_cnt_q, p1_cnt_d;
    logic [AW-1:0] p1_addr_q, p1_addr_d, p1_rd_addr;
    logic          p1_load;
    logic [15:0]   data1_q, data1_d;

    state_e        p2_state_q, p2_state_d;
    logic [3:0]    p2_cnt_q, p2_cnt_d;
    logic [AW-1:0] p2_addr_q, p2_addr_d, p2_rd_addr;
    logic          p2_wr_q, p2_wr_d;
    logic [15:0]   p2_wdata_q, p2_wdata_d;
    logic          p2_load;
    logic [15:0]   data2_q, data2_d;
    logic          p2_commit;

    // Address bits above the array index are deliberately dropped (aliasing).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{address1, address2};

    assign ready1    = (p1_state_q == ST_DONE);
    assign ready2    = (p2_state_q == ST_DONE);
    assign data1     = data1_q;
    assign p2_commit = (p2_state_q == ST_DONE) && p2_wr_q;
    assign data2     = ((p2_state_q == ST_DONE) && !p2_wr_q) ? data2_q : 16'hzzzz;

    // Instruction port: accept, count down the latency, present one-cycle ready.
    // When the read lands in DONE straight from IDLE, the array is indexed by the
    // live address because the latch is only being loaded on that same edge.
    always_comb begin
        p1_state_d = p1_state_q;
        p1_cnt_d   = p1_cnt_q;
        p1_addr_d  = p1_addr_q;
        p1_rd_addr = p1_addr_q;
        p1_load    = 1'b0;
        case (p1_state_q)
            ST_IDLE: begin
                if (read_m1) begin
                    p1_addr_d  = address1[AW-1:0];
                    p1_rd_addr = address1[AW-1:0];
                    p1_cnt_d   = CNT_LOAD;
                    if (DIRECT_DONE) begin
                        p1_state_d = ST_DONE;
                        p1_load    = 1'b1;
                    end else begin
                        p1_state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                p1_cnt_d = p1_cnt_q - 4'd1;
                if (p1_cnt_q == 4'd1) begin
                    p1_state_d = ST_DONE;
                    p1_load    = 1'b1;
                end
            end
            ST_DONE: p1_state_d = ST_IDLE;
            default: p1_state_d = ST_IDLE;
        endcase
        data1_d = p1_load ? mem_q[p1_rd_addr] : data1_q;
    end

    // Data port: same sequencing; a simultaneous read+write request is a write.
    always_comb begin
        p2_state_d = p2_state_q;
        p2_cnt_d   = p2_cnt_q;
        p2_addr_d  = p2_addr_q;
        p2_wr_d    = p2_wr_q;
        p2_wdata_d = p2_wdata_q;
        p2_rd_addr = p2_addr_q;
        p2_load    = 1'b0;
        case (p2_state_q)
            ST_IDLE: begin
                if (read_m2 || write_m2) begin
                    p2_addr_d  = address2[AW-1:0];
                    p2_rd_addr = address2[AW-1:0];
                    p2_wr_d    = write_m2;
                    p2_wdata_d = data2;
                    p2_cnt_d   = CNT_LOAD;
                    if (DIRECT_DONE) begin
                        p2_state_d = ST_DONE;
                        p2_load    = !write_m2;
                    end else begin
                        p2_state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                p2_cnt_d = p2_cnt_q - 4'd1;
                if (p2_cnt_q == 4'd1) begin
                    p2_state_d = ST_DONE;
                    p2_load    = !p2_wr_q;
                end
            end
            ST_DONE: p2_state_d = ST_IDLE;
            default: p2_state_d = ST_IDLE;
        endcase
        data2_d = p2_load ? mem_q[p2_rd_addr] : data2_q;
    end

    // Instruction port state register.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            p1_state_q <= ST_IDLE;
            p1_cnt_q   <= '0;
            p1_addr_q  <= '0;
            data1_q    <= '0;
        end else begin
            p1_state_q <= p1_state_d;
            p1_cnt_q   <= p1_cnt_d;
            p1_addr_q  <= p1_addr_d;
            data1_q    <= data1_d;
        end
    end

    // Data port state register.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            p2_state_q <= ST_IDLE;
            p2_cnt_q   <= '0;
            p2_addr_q  <= '0;
            p2_wr_q    <= 1'b0;
            p2_wdata_q <= '0;
            data2_q    <= '0;
        end else begin
            p2_state_q <= p2_state_d;
            p2_cnt_q   <= p2_cnt_d;
            p2_addr_q  <= p2_addr_d;
            p2_wr_q    <= p2_wr_d;
            p2_wdata_q <= p2_wdata_d;
            data2_q    <= data2_d;
        end
    end

    // Array: cleared on reset, written on the edge that closes a write's DONE cycle.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (p2_commit) begin
            mem_q[p2_addr_q] <= p2_wdata_q;
        end
    end
endmodule

// File: tb/tb_memory_responder.sv
// tb/tb_memory_responder.sv - bench for memory_responder at latency 2 and latency 1
module tb_memory_responder;
    localparam int DEPTH = 256;
    localparam int LAT_A = 2;
    localparam int LAT_B = 1;

    logic        clk = 1'b0;
    logic        reset_n, read_m1, read_m2, write_m2;
    logic [15:0] address1, address2, wdata;
    logic        drv_a = 1'b0;
    logic        drv_b = 1'b0;
    logic [15:0] data1_a, data1_b;
    logic        ready1_a, ready1_b, ready2_a, ready2_b;
    wire  [15:0] data2_a, data2_b;

    int total = 0;
    int bad = 0;
    int edge_n = 0;

    always #5 clk = ~clk;

    pulldown (data2_a);
    pulldown (data2_b);
    assign data2_a = (write_m2 && !drv_a) ? wdata : 16'hzzzz;
    assign data2_b = (write_m2 && !drv_b) ? wdata : 16'hzzzz;

    memory_responder #(.MEM_DEPTH(DEPTH), .LATENCY(LAT_A)) dut_a (
        .clk(clk), .reset_n(reset_n),
        .read_m1(read_m1), .address1(address1), .data1(data1_a), .ready1(ready1_a),
        .read_m2(read_m2), .write_m2(write_m2), .address2(address2),
        .data2(data2_a), .ready2(ready2_a)
    );

    memory_responder #(.MEM_DEPTH(DEPTH), .LATENCY(LAT_B)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .read_m1(read_m1), .address1(address1), .data1(data1_b), .ready1(ready1_b),
        .read_m2(read_m2), .write_m2(write_m2), .address2(address2),
        .data2(data2_b), .ready2(ready2_b)
    );

    // Transaction-level reference: one outstanding request per port, timed by edge numbers.
    logic [15:0] m_mem [2][DEPTH];
    bit          m1_act [2];
    bit          m2_act [2];
    bit          m2_wr [2];
    int          m1_acc [2];
    int          m2_acc [2];
    int          m1_addr [2];
    int          m2_addr [2];
    logic [15:0] m2_wdata [2];
    logic [15:0] m_data1 [2];
    logic [15:0] m_data2 [2];
    bit          m_ready1 [2];
    bit          m_ready2 [2];
    bit          m_drive2 [2];

    function automatic int lat_of(input int i);
        return (i == 0) ? LAT_A : LAT_B;
    endfunction

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            int l;
            l = lat_of(i);
            if (reset_n) begin
                m1_act[i] = 1'b0;
                m2_act[i] = 1'b0;
                m_data1[i] = 16'h0000;
                m_data2[i] = 16'h0000;
                for (int a = 0; a < DEPTH; a++) m_mem[i][a] = 16'h0000;
            end else begin
                if (!m1_act[i] && read_m1) begin
                    m1_act[i]  = 1'b1;
                    m1_acc[i]  = edge_n;
                    m1_addr[i] = int'(address1) % DEPTH;
                end
                if (!m2_act[i] && (read_m2 || write_m2)) begin
                    m2_act[i]   = 1'b1;
                    m2_acc[i]   = edge_n;
                    m2_addr[i]  = int'(address2) % DEPTH;
                    m2_wr[i]    = write_m2;
                    m2_wdata[i] = wdata;
                end
                if (m1_act[i] && edge_n == m1_acc[i] + l - 1)
                    m_data1[i] = m_mem[i][m1_addr[i]];
                if (m2_act[i] && !m2_wr[i] && edge_n == m2_acc[i] + l - 1)
                    m_data2[i] = m_mem[i][m2_addr[i]];
                if (m2_act[i] && edge_n == m2_acc[i] + l) begin
                    if (m2_wr[i]) m_mem[i][m2_addr[i]] = m2_wdata[i];
                    m2_act[i] = 1'b0;
                end
                if (m1_act[i] && edge_n == m1_acc[i] + l) m1_act[i] = 1'b0;
            end
            m_ready1[i] = m1_act[i] && (edge_n == m1_acc[i] + l - 1);
            m_ready2[i] = m2_act[i] && (edge_n == m2_acc[i] + l - 1);
            m_drive2[i] = m_ready2[i] && !m2_wr[i];
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        edge_n++;
        model_step();
        #1;
        drv_a = m_drive2[0];
        drv_b = m_drive2[1];
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        read_m1 = 1'b0;
        read_m2 = 1'b0;
        write_m2 = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        read_m1 = 1'b1;
        address1 = 16'h0000;
        read_m2 = 1'b0;
        write_m2 = 1'b0;
        address2 = 16'h0000;
        wdata = 16'h0000;
        cycle();
        cycle();
        total++; if (ready1_a !== 1'b0) begin bad++; $display("FAIL reset_ready1: got %b want 0", ready1_a); end
        total++; if (ready2_a !== 1'b0) begin bad++; $display("FAIL reset_ready2: got %b want 0", ready2_a); end
        total++; if (data1_a !== 16'h0000) begin bad++; $display("FAIL reset_data1: got %h want 0000", data1_a); end
        total++; if (data2_a !== 16'h0000) begin bad++; $display("FAIL reset_data2_bus: got %h want 0000", data2_a); end
        total++; if (ready1_b !== 1'b0) begin bad++; $display("FAIL reset_ready1_l1: got %b want 0", ready1_b); end
        reset_n = 1'b0;
        cycle();
        total++; if (ready1_a !== 1'b0) begin bad++; $display("FAIL post_reset_k1: got %b want 0", ready1_a); end
        total++; if (ready1_b !== 1'b1) begin bad++; $display("FAIL post_reset_k1_l1: got %b want 1", ready1_b); end
        read_m1 = 1'b0;
        cycle();
        total++; if (ready1_a !== 1'b1) begin bad++; $display("FAIL post_reset_k2: got %b want 1", ready1_a); end
        cycle();
    endtask

    task automatic test_write_read();
        write_m2 = 1'b1;
        address2 = 16'h0005;
        wdata = 16'hBEEF;
        for (int k = 1; k <= 4; k++) begin
            cycle();
            total++;
            if (ready2_a !== (k == 2)) begin
                bad++; $display("FAIL write_ready2_k%0d: got %b want %b", k, ready2_a, (k == 2));
            end
            idle_inputs();
        end
        read_m1 = 1'b1;
        address1 = 16'h0005;
        for (int k = 1; k <= 4; k++) begin
            cycle();
            total++;
            if (ready1_a !== (k == 2)) begin
                bad++; $display("FAIL read_ready1_k%0d: got %b want %b", k, ready1_a, (k == 2));
            end
            if (k >= 2) begin
                total++;
                if (data1_a !== 16'hBEEF) begin
                    bad++; $display("FAIL read_data1_k%0d: got %h want beef", k, data1_a);
                end
            end
            idle_inputs();
        end
    endtask

    task automatic test_back_to_back();
        read_m1 = 1'b1;
        address1 = 16'h0005;
        for (int k = 1; k <= 12; k++) begin
            cycle();
            total++;
            if (ready1_a !== ((k % 3) == 2)) begin
                bad++; $display("FAIL b2b_ready1_k%0d: got %b want %b", k, ready1_a, ((k % 3) == 2));
            end
            total++;
            if (ready1_b !== ((k % 2) == 1)) begin
                bad++; $display("FAIL b2b_ready1_l1_k%0d: got %b want %b", k, ready1_b, ((k % 2) == 1));
            end
        end
        idle_inputs();
        cycle();
        cycle();
    endtask

    task automatic test_rw_both();
        read_m2 = 1'b1;
        address2 = 16'h0005;
        cycle();
        idle_inputs();
        cycle();
        total++; if (data2_a !== 16'hBEEF) begin bad++; $display("FAIL p2_read_bus: got %h want beef", data2_a); end
        cycle();
        total++; if (data2_a !== 16'h0000) begin bad++; $display("FAIL p2_release_bus: got %h want 0000", data2_a); end
        read_m2 = 1'b1;
        write_m2 = 1'b1;
        address2 = 16'h0003;
        wdata = 16'h1234;
        cycle();
        idle_inputs();
        for (int k = 2; k <= 4; k++) begin
            cycle();
            total++;
            if (data2_a !== 16'h0000) begin
                bad++; $display("FAIL rw_both_undriven_k%0d: got %h want 0000", k, data2_a);
            end
        end
        read_m1 = 1'b1;
        address1 = 16'h0003;
        read_m2 = 1'b1;
        address2 = 16'h0003;
        cycle();
        idle_inputs();
        cycle();
        total++; if (data1_a !== 16'h1234) begin bad++; $display("FAIL rw_both_p1: got %h want 1234", data1_a); end
        total++; if (data2_a !== 16'h1234) begin bad++; $display("FAIL rw_both_p2: got %h want 1234", data2_a); end
        cycle();
    endtask

    task automatic test_wrap();
        write_m2 = 1'b1;
        address2 = 16'h0107;
        wdata = 16'hAAAA;
        cycle();
        idle_inputs();
        cycle();
        cycle();
        read_m1 = 1'b1;
        address1 = 16'h0007;
        cycle();
        idle_inputs();
        cycle();
        total++; if (data1_a !== 16'hAAAA) begin bad++; $display("FAIL wrap: got %h want aaaa", data1_a); end
        cycle();
    endtask

    task automatic test_reset_inflight();
        write_m2 = 1'b1;
        address2 = 16'h0020;
        wdata = 16'h5555;
        cycle();
        idle_inputs();
        reset_n = 1'b1;
        cycle();
        reset_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (ready2_a !== 1'b0) begin
                bad++; $display("FAIL inflight_ready2_k%0d: got %b want 0", k, ready2_a);
            end
            cycle();
        end
        read_m1 = 1'b1;
        address1 = 16'h0020;
        cycle();
        total++; if (data1_b !== 16'h0000) begin bad++; $display("FAIL inflight_read_l1: got %h want 0000", data1_b); end
        idle_inputs();
        cycle();
        total++; if (data1_a !== 16'h0000) begin bad++; $display("FAIL inflight_read: got %h want 0000", data1_a); end
        cycle();
    endtask

    task automatic test_same_cycle_l1();
        read_m1 = 1'b1;
        address1 = 16'h0010;
        write_m2 = 1'b1;
        address2 = 16'h0010;
        wdata = 16'hCAFE;
        cycle();
        total++; if (ready1_b !== 1'b1) begin bad++; $display("FAIL same_ready1_l1: got %b want 1", ready1_b); end
        total++; if (data1_b !== 16'h0000) begin bad++; $display("FAIL same_old_l1: got %h want 0000", data1_b); end
        idle_inputs();
        cycle();
        total++; if (data1_a !== 16'h0000) begin bad++; $display("FAIL same_old_l2: got %h want 0000", data1_a); end
        cycle();
        read_m1 = 1'b1;
        cycle();
        total++; if (data1_b !== 16'hCAFE) begin bad++; $display("FAIL same_new_l1: got %h want cafe", data1_b); end
        idle_inputs();
        cycle();
        total++; if (data1_a !== 16'hCAFE) begin bad++; $display("FAIL same_new_l2: got %h want cafe", data1_a); end
        cycle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            logic [15:0] a1, a2;
            reset_n = ($urandom_range(0, 79) == 0);
            read_m1 = $urandom_range(0, 1);
            read_m2 = ($urandom_range(0, 2) == 0);
            write_m2 = ($urandom_range(0, 2) == 0);
            a1 = 16'($urandom);
            a1[7:3] = 5'd0;
            a2 = 16'($urandom);
            a2[7:3] = 5'd0;
            address1 = a1;
            address2 = a2;
            wdata = 16'($urandom);
            cycle();
            for (int i = 0; i < 2; i++) begin
                logic        r1, r2, tb_drv;
                logic [15:0] d1, d2, want2;
                r1 = (i == 0) ? ready1_a : ready1_b;
                r2 = (i == 0) ? ready2_a : ready2_b;
                d1 = (i == 0) ? data1_a : data1_b;
                d2 = (i == 0) ? data2_a : data2_b;
                tb_drv = write_m2 && !m_drive2[i];
                total++;
                if (r1 !== m_ready1[i]) begin
                    bad++; $display("FAIL rnd_ready1 inst%0d edge%0d: got %b want %b", i, edge_n, r1, m_ready1[i]);
                end
                total++;
                if (r2 !== m_ready2[i]) begin
                    bad++; $display("FAIL rnd_ready2 inst%0d edge%0d: got %b want %b", i, edge_n, r2, m_ready2[i]);
                end
                total++;
                if (d1 !== m_data1[i]) begin
                    bad++; $display("FAIL rnd_data1 inst%0d edge%0d: got %h want %h", i, edge_n, d1, m_data1[i]);
                end
                if (!tb_drv) begin
                    want2 = m_drive2[i] ? m_data2[i] : 16'h0000;
                    total++;
                    if (d2 !== want2) begin
                        bad++; $display("FAIL rnd_data2 inst%0d edge%0d: got %h want %h", i, edge_n, d2, want2);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_rw_both();
        test_wrap();
        test_reset_inflight();
        test_same_cycle_l1();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 Parameter MEM_DEPTH, default 256: number of 16-bit words; address uses low log2(MEM_DEPTH) bits.
REQ-002 Parameter LATENCY, default 2, legal range 1..15: cycles from request accept to ready.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 reset_n  input  1  reset, synchronous and active-high (asserted = 1, sampled on rising clk).
REQ-005 read_m1  input  1  instruction-port read request.
REQ-006 address1  input  16  instruction-port word address.
REQ-007 data1  output  16  instruction-port read data, registered.
REQ-008 ready1  output  1  instruction-port completion strobe, one cycle.
REQ-009 read_m2  input  1  data-port read request.
REQ-010 write_m2  input  1  data-port write request.
REQ-011 address2  input  16  data-port word address.
REQ-012 data2  inout  16  data-port bus: write data in, read data out.
REQ-013 ready2  output  1  data-port completion strobe, one cycle.

Function
REQ-014 Each port shall run an independent FSM: IDLE -> WAIT -> DONE -> IDLE.
REQ-015 IDLE: request high at a rising edge -> accept; latch address (and for writes, data2); load counter with LATENCY-1; go WAIT (or DONE directly when LATENCY=1).
REQ-016 WAIT: decrement counter each cycle; at counter 0 go DONE.
REQ-017 Accept in cycle T -> ready high exactly in cycle T+LATENCY, for one cycle only.
REQ-018 DONE: ready high; request present during DONE shall not be accepted; next accept earliest cycle T+LATENCY+1.
REQ-019 Read: data1/data2 output loaded on edge entering DONE from array at latched address, read-old value if a write commits on that same edge.
REQ-020 Write: array updated at latched address with latched data on the edge ending the DONE cycle.
REQ-021 read_m2 and write_m2 both high at accept -> treated as write.
REQ-022 data2 driven only in DONE of a data-port read; high-Z at all other times.
REQ-023 data1 holds last read value outside DONE.
REQ-024 Address bits above log2(MEM_DEPTH) ignored (wrap modulo MEM_DEPTH); address 16'h0100 aliases 16'h0000 at default depth.
REQ-025 Request deasserted or address changed after accept: transaction still completes on latched values; no abort.
REQ-026 Both ports may be busy simultaneously; port 1 read of a location written by port 2 sees new data only if the write committed on or before the edge before port 1 enters DONE.

Reset
REQ-027 reset_n high at a rising edge: both FSMs IDLE, counters 0, ready1=ready2=0, data1=16'h0000, data2 high-Z, all array words 0; in-flight transactions discarded, pending writes not committed.
REQ-028 Requests sampled on the reset edge shall be ignored; first accept on the edge after reset deasserts.

Verification
REQ-029 LATENCY=2: write_m2=1, address2=16'h0005, data2=16'hBEEF at cycle T -> ready2 only in T+2; then read_m1 at 16'h0005 -> data1=16'hBEEF with ready1 two cycles after accept.
REQ-030 read_m1 held high continuously, LATENCY=2 -> ready1 pulses every 3 cycles, never two consecutive cycles.
REQ-031 read_m2 and write_m2 both high, address2=16'h0003, data2=16'h1234 -> data2 never driven by DUT; later read of 3 returns 16'h1234.
REQ-032 Write 16'hAAAA to 16'h0107, read 16'h0007 -> 16'hAAAA (wrap).
REQ-033 Write accepted, reset_n pulsed high in WAIT -> ready2 never asserts; subsequent read of that address returns 16'h0000.
REQ-034 Port 1 read and port 2 write of address 16'h0010 accepted same cycle, LATENCY=1 -> data1 returns old value 16'h0000; next read returns new value.
